// File: rtl/bp_mem_block_responder.sv
// Block-addressed backing store that answers one block-level memory request at a time.
// It stands in for DRAM behind the BP mem transducer in ME testbenches.
//
// Optional feature: define BP_MEM_BLOCK_RESPONDER_RAND_LAT_EN to add 0-7 cycles of
// deterministic per-request jitter. The jitter comes from an 8-bit Fibonacci LFSR.
//
// Ports:
//   clk_i        - clock
//   reset_n_i    - synchronous active-low reset
//   ready_o      - responder is idle and can accept a request
//   v_i, w_i     - request valid / request is a write
//   addr_i       - block-aligned byte address; index bits select the block, others ignored
//   data_i       - write data, already lane-positioned
//   write_mask_i - per-byte write enable
//   data_o, v_o  - response data / valid, held until yumi_i
//   yumi_i       - response consumed
module bp_mem_block_responder #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned els_p         = 256,
  parameter int unsigned latency_p     = 4,
  parameter logic [7:0]  lfsr_seed_p   = 8'hA5
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       ready_o,
  input  logic                       v_i,
  input  logic                       w_i,
  input  logic [paddr_width_p-1:0]   addr_i,
  input  logic [block_width_p-1:0]   data_i,
  input  logic [block_width_p/8-1:0] write_mask_i,
  output logic [block_width_p-1:0]   data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  localparam int unsigned BYTES_LP = block_width_p / 8;
  localparam int unsigned OFF_W    = $clog2(BYTES_LP);
  localparam int unsigned IDX_W    = $clog2(els_p);
`ifdef BP_MEM_BLOCK_RESPONDER_RAND_LAT_EN
  localparam int unsigned CNT_W    = $clog2(latency_p + 9);
`else
  localparam int unsigned CNT_W    = $clog2(latency_p + 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                   r_state;
  logic                     r_ready;
  logic                     r_v;
  logic [block_width_p-1:0] r_data;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_w;
  logic [block_width_p-1:0] r_mem [els_p];

  logic [IDX_W-1:0]         w_idx;
  logic                     w_accept;
  logic [CNT_W-1:0]         w_load;

  // Upper and offset address bits do not participate in block selection.
  logic w_unused_addr;
  assign w_unused_addr = ^{addr_i[paddr_width_p-1:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

  assign w_idx    = addr_i[OFF_W +: IDX_W];
  assign w_accept = reset_n_i & r_ready & v_i;

`ifdef BP_MEM_BLOCK_RESPONDER_RAND_LAT_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  // Fibonacci LFSR, taps 8,6,5,4, stepped once per accepted request.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_load    = CNT_W'(latency_p) + CNT_W'(r_lfsr[2:0]);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_lfsr <= lfsr_seed_p;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  logic w_unused_seed;
  assign w_unused_seed = ^lfsr_seed_p;
  assign w_load        = CNT_W'(latency_p);
`endif

  // Backing store: byte-masked write in the accept cycle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_i) begin
      for (int b = 0; b < int'(BYTES_LP); b++) begin
        if (write_mask_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= data_i[b*8 +: 8];
        end
      end
    end
  end

  // Request sequencing: IDLE -> WAIT (latency countdown) -> RESP (hold until yumi).
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_v     <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_w     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_w     <= w_i;
            r_cnt   <= w_load;
            r_ready <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            // Write responses carry no data.
            r_data  <= r_w ? '0 : r_mem[r_idx];
            r_v     <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (yumi_i) begin
            r_v     <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_v     <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign v_o     = r_v;
  assign data_o  = r_data;

endmodule

// File: tb/tb_bp_mem_block_responder.sv
// Directed bench for bp_mem_block_responder with a transaction-level reference model.
module tb_bp_mem_block_responder;

  localparam int unsigned LAT = 4;
  localparam int unsigned BW  = 512;
  localparam int unsigned MW  = BW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ready;
  logic          v_i;
  logic          w_i;
  logic [39:0]   addr;
  logic [BW-1:0] data_i;
  logic [MW-1:0] mask;
  logic [BW-1:0] data_o;
  logic          v_o;
  logic          yumi;

  int n_checks = 0;
  int n_fail   = 0;

  bp_mem_block_responder #(
    .paddr_width_p(40),
    .block_width_p(BW),
    .els_p        (256),
    .latency_p    (LAT),
    .lfsr_seed_p  (8'hA5)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .ready_o     (ready),
    .v_i         (v_i),
    .w_i         (w_i),
    .addr_i      (addr),
    .data_i      (data_i),
    .write_mask_i(mask),
    .data_o      (data_o),
    .v_o         (v_o),
    .yumi_i      (yumi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, response due latency+2 cycles after accept.
  bit            m_known = 1'b0;
  bit            m_pend  = 1'b0;
  int            m_left  = 0;
  logic [BW-1:0] m_data;
  logic [BW-1:0] m_mem [256];

  always @(negedge clk) begin
    bit exp_v;
    bit exp_ready;
    int idx;
    if (m_pend && m_left > 0) m_left--;
    exp_v     = m_pend && (m_left == 0);
    exp_ready = !m_pend;
    if (m_known) begin
      check("ready_o", BW'(ready), BW'(exp_ready));
      check("v_o", BW'(v_o), BW'(exp_v));
      if (exp_v) check("data_o", data_o, m_data);
    end
    if (!reset_n) begin
      m_pend  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (exp_v && yumi) begin
        m_pend = 1'b0;
      end else if (exp_ready && v_i) begin
        idx = int'((addr / 40'd64) % 40'd256);
        if (w_i) begin
          for (int b = 0; b < int'(MW); b++)
            if (mask[b]) m_mem[idx][b*8 +: 8] = data_i[b*8 +: 8];
          m_data = '0;
        end else begin
          m_data = m_mem[idx];
        end
        m_pend = 1'b1;
        m_left = int'(LAT) + 2;
      end
    end
  end

  // Issue one request, wait for its response, optionally backpressure, then consume it.
  task automatic do_req(input logic wr, input logic [39:0] a, input logic [BW-1:0] d,
                        input logic [MW-1:0] m, input int hold, input bit spur,
                        output logic [BW-1:0] rd, output int lat, output int waits);
    v_i = 1'b1; w_i = wr; addr = a; data_i = d; mask = m; waits = 0;
    while (!ready && waits < 50) begin
      @(posedge clk); #1; waits++;
    end
    @(posedge clk); #1;
    v_i = 1'b0; w_i = 1'b0; mask = '0;
    lat = 1;
    while (!v_o && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    if (!v_o) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: v_o still 0 after %0d cycles, required 1", lat);
    end
    rd = data_o;
    for (int i = 0; i < hold; i++) begin
      if (spur && i == 2) begin v_i = 1'b1; w_i = 1'b0; addr = 40'h4000; end
      if (spur && i == 6) v_i = 1'b0;
      @(posedge clk); #1;
    end
    if (hold > 0) check("hold_data", data_o, rd);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] pat, pat2, part, rd;
    int lat, waits, seen;
    pat  = {8{64'hDEADBEEF_DEADBEEF}};
    pat2 = {8{64'h0123456789ABCDEF}};
    part = {{7{64'hDEADBEEF_DEADBEEF}}, 64'h1122334455667788};

    reset_n = 1'b0; v_i = 1'b0; w_i = 1'b0; addr = '0; data_i = '0; mask = '0; yumi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_ready", BW'(ready), BW'(1));
    check("rst_v", BW'(v_o), BW'(0));
    check("rst_data", data_o, '0);

    // Stray yumi while idle.
    yumi = 1'b1; @(posedge clk); #1; yumi = 1'b0;
    check("stray_yumi_v", BW'(v_o), BW'(0));

    do_req(1'b1, 40'h80, pat, '1, 0, 1'b0, rd, lat, waits);
    check("wr_lat", BW'(lat), BW'(6));
    check("wr_resp_zero", rd, '0);

    do_req(1'b0, 40'h80, '0, '0, 0, 1'b0, rd, lat, waits);
    check("rd_full", rd, pat);
    check("rd_lat", BW'(lat), BW'(6));
    check("b2b_no_wait", BW'(waits), BW'(0));

    do_req(1'b1, 40'h80, {448'h0, 64'h1122334455667788}, 64'h00FF, 0, 1'b0, rd, lat, waits);
    do_req(1'b0, 40'h80, '0, '0, 0, 1'b0, rd, lat, waits);
    check("rd_partial", rd, part);

    do_req(1'b1, 40'h4000, pat2, '1, 0, 1'b0, rd, lat, waits);
    do_req(1'b0, 40'h0, '0, '0, 0, 1'b0, rd, lat, waits);
    check("rd_alias", rd, pat2);

    // All-zero mask: must still respond, and must not modify storage.
    do_req(1'b1, 40'h80, '1, '0, 0, 1'b0, rd, lat, waits);
    check("zmask_lat", BW'(lat), BW'(6));
    do_req(1'b0, 40'h80, '0, '0, 0, 1'b0, rd, lat, waits);
    check("zmask_rd", rd, part);

    do_req(1'b0, 40'h80, '0, '0, 10, 1'b1, rd, lat, waits);
    check("bp_rd", rd, part);

    // Reset while in WAIT drops the read.
    v_i = 1'b1; w_i = 1'b0; addr = 40'h80;
    @(posedge clk); #1; v_i = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (v_o) seen++;
      @(posedge clk); #1;
    end
    check("dropped_no_v", BW'(seen), BW'(0));
    do_req(1'b0, 40'h80, '0, '0, 0, 1'b0, rd, lat, waits);
    check("post_rst_rd", rd, part);
    check("post_rst_lat", BW'(lat), BW'(6));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
